// File: rtl/tick_serial_tx_pkg.sv
// Shared types and helpers for the tick-driven serial transmitter:
// FSM state encoding, data-width limits and the frame parity function.
package tick_serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 8;

  // XOR of the low nbits of data, inverted when odd parity is selected.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input int nbits,
                                       input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/tick_serial_tx_sync_fifo.sv
// Small power-of-two FIFO with registered not-full flag and occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_not_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_not_full;
  logic             w_do_push;
  logic             w_do_pop;
  logic [LW-1:0]    w_level_next;

  assign w_do_push    = i_push & r_not_full;
  assign w_do_pop     = i_pop & (r_level != '0);
  assign w_level_next = r_level + LW'(w_do_push) - LW'(w_do_pop);

  // not-full is derived from the next level so a filling push closes ready at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_not_full <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level    <= w_level_next;
      r_not_full <= (w_level_next != LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_empty    = (r_level == '0);
  assign o_not_full = r_not_full;
  assign o_level    = r_level;

endmodule

// File: rtl/tick_serial_tx.sv
// Serial byte transmitter paced by an external bit-rate strobe: FIFO-buffered
// bytes are framed as start, LSB-first data, optional parity and stop bits.
module tick_serial_tx
  import tick_serial_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bit_tick,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("tick_serial_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("tick_serial_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tick_serial_tx: FIFO_DEPTH must be a power of 2, >= 2");
  end

  tx_state_t              r_state;
  logic                   r_tick_s;
  logic                   r_tick_d;
  logic                   r_tx;
  logic [CW-1:0]          r_bit_cnt;
  logic                   r_stop_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity;

  logic                   w_tick_p;
  logic                   w_empty;
  logic                   w_not_full;
  logic                   w_stop_done;
  logic                   w_pop;
  logic                   w_shift_en;
  logic [DATA_BITS-1:0]   w_fifo_data;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (in_valid),
    .i_data     (in_data),
    .i_pop      (w_pop),
    .o_data     (w_fifo_data),
    .o_empty    (w_empty),
    .o_not_full (w_not_full),
    .o_level    (level)
  );

  // Rising-edge detect works for both pulse and square-wave strobes
  assign w_tick_p    = r_tick_s & ~r_tick_d;
  assign w_stop_done = (r_stop_cnt == STOP_LAST);
  assign w_pop       = w_tick_p & ~w_empty &
                       ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_stop_done));
  assign w_shift_en  = w_tick_p & (r_state == ST_DATA) & (r_bit_cnt != BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_s <= 1'b0;
      r_tick_d <= 1'b0;
    end else begin
      r_tick_s <= bit_tick;
      r_tick_d <= r_tick_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
    end else if (w_tick_p) begin
      unique case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_tx      <= r_shift[0];
          r_bit_cnt <= '0;
          r_state   <= ST_DATA;
        end
        ST_DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              r_tx    <= r_parity;
              r_state <= ST_PARITY;
            end else begin
              r_tx       <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= ST_STOP;
            end
          end else begin
            r_tx      <= r_shift[1];
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          r_tx       <= 1'b1;
          r_stop_cnt <= 1'b0;
          r_state    <= ST_STOP;
        end
        ST_STOP: begin
          if (w_stop_done) begin
            // Chain straight into the next start bit when more data is queued
            if (!w_empty) begin
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift  <= w_fifo_data;
      r_parity <= calc_parity(MAX_DATA_BITS'(w_fifo_data), DATA_BITS, (PARITY_ODD != 0));
    end else if (w_shift_en) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign tx       = r_tx;
  assign in_ready = w_not_full;
  assign busy     = (r_state != ST_IDLE) | (level != '0);

endmodule

// File: tb/tb_tick_serial_tx.sv
// Bench for tick_serial_tx: three instances (plain 8N1, even parity, odd parity
// with two stop bits) checked by a sampling frame receiver and a byte scoreboard.
module tb_tick_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_tick = 1'b0;
  logic [7:0] in_data_a = 8'h00;
  logic       in_valid_a = 1'b0;
  logic [7:0] in_data_p = 8'h00;
  logic       in_valid_p = 1'b0;

  logic       in_ready_a, tx_a, busy_a;
  logic [2:0] level_a;
  logic       in_ready_b, tx_b, busy_b;
  logic [2:0] level_b;
  logic       in_ready_c, tx_c, busy_c;
  logic [2:0] level_c;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int cyc = 0;
  int tick_mode = 0;
  int tc = 0;
  int bit_T = 10;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         starts0[$];
  logic       par_log1[$];
  logic       par_log2[$];

  int         m_act[3];
  int         m_cnt[3];
  int         m_k[3];
  logic [7:0] m_dat[3];
  logic       m_par[3];
  logic       m_bad[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tick_serial_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .tx(tx_a), .busy(busy_a), .level(level_a));

  tick_serial_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .in_data(in_data_p), .in_valid(in_valid_p),
    .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b), .level(level_b));

  tick_serial_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .in_data(in_data_p), .in_valid(in_valid_p),
    .in_ready(in_ready_c), .tx(tx_c), .busy(busy_c), .level(level_c));

  // Strobe generator: 0 = held low, 1 = 1-clk pulse every 10 clk, 2 = square wave of period 20
  initial begin
    forever begin
      @(negedge clk);
      case (tick_mode)
        0:       bit_tick = 1'b0;
        1:       bit_tick = ((tc % 10) == 0);
        default: bit_tick = ((tc % 20) < 10);
      endcase
      tc++;
    end
  end

  function automatic int frame_bits(input int i);
    return 1 + 8 + ((i == 0) ? 0 : 1) + ((i == 2) ? 2 : 1);
  endfunction

  // Receiver: detects the start bit, samples every bit centre, then scores the byte.
  task automatic mon_step(input int i, input logic txv);
    logic [7:0] e;
    logic       ep;
    bit         have;
    if (rst_n !== 1'b1) begin
      m_act[i] = 0;
      return;
    end
    if (m_act[i] == 0) begin
      if (txv === 1'b0) begin
        m_act[i] = 1; m_cnt[i] = 0; m_k[i] = 0;
        m_dat[i] = 8'h00; m_bad[i] = 1'b0; m_par[i] = 1'b0;
        if (i == 0) starts0.push_back(cyc);
      end
    end else begin
      m_cnt[i]++;
      if (m_cnt[i] == m_k[i] * bit_T + bit_T / 2) begin
        if (m_k[i] == 0) begin
          if (txv !== 1'b0) m_bad[i] = 1'b1;
        end else if (m_k[i] <= 8) begin
          m_dat[i][m_k[i]-1] = txv;
        end else if (m_k[i] == 9 && i != 0) begin
          m_par[i] = txv;
        end else if (txv !== 1'b1) begin
          m_bad[i] = 1'b1;
        end
        m_k[i]++;
        if (m_k[i] == frame_bits(i)) begin
          m_act[i] = 0;
          have = 0;
          e = 8'h00;
          case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
          endcase
          if (i == 1) par_log1.push_back(m_par[1]);
          if (i == 2) par_log2.push_back(m_par[2]);
          ep = (^e) ^ (i == 2);
          vec_cnt++;
          if (!have) begin
            miss_cnt++;
            $display("FAIL rx_frame dut%0d: got byte %02h, required no frame (nothing queued)", i, m_dat[i]);
          end else if (m_bad[i] || m_dat[i] !== e || (i != 0 && m_par[i] !== ep)) begin
            miss_cnt++;
            $display("FAIL rx_frame dut%0d: got data %02h parity %b framing_err %b, required data %02h parity %b framing_err 0",
                     i, m_dat[i], m_par[i], m_bad[i], e, ep);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, tx_a);
    mon_step(1, tx_b);
    mon_step(2, tx_c);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_ticks(input int mode);
    @(posedge clk);
    tick_mode = mode;
    tc = 0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid_a = 1'b0;
    in_valid_p = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    starts0.delete(); par_log1.delete(); par_log2.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] d, input int budget, output bit ok);
    @(negedge clk);
    in_data_a = d;
    in_valid_a = 1'b1;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      if (in_ready_a === 1'b1) begin
        ok = 1;
        q0.push_back(d);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid_a = 1'b0;
  endtask

  task automatic push_p(input logic [7:0] d, input int budget, output bit ok);
    @(negedge clk);
    in_data_p = d;
    in_valid_p = 1'b1;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      if (in_ready_b === 1'b1 && in_ready_c === 1'b1) begin
        ok = 1;
        q1.push_back(d);
        q2.push_back(d);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid_p = 1'b0;
  endtask

  task automatic wait_start(input int n, input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (starts0.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget, output int at, output bit ok);
    ok = 0;
    at = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy_a === 1'b0 && busy_b === 1'b0 && busy_c === 1'b0) begin
        ok = 1; at = cyc; break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if (tx_a !== 1'b1) begin miss_cnt++; $display("FAIL reset_tx: got %b, required 1", tx_a); end
    vec_cnt++; if (busy_a !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
    vec_cnt++; if (in_ready_a !== 1'b0) begin miss_cnt++; $display("FAIL reset_in_ready: got %b, required 0", in_ready_a); end
    vec_cnt++; if (level_a !== 3'd0) begin miss_cnt++; $display("FAIL reset_level: got %0d, required 0", level_a); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++; if (in_ready_a !== 1'b1) begin miss_cnt++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready_a); end
  endtask

  task automatic test_basic_frame();
    bit ok;
    int t0, s, b;
    logic [9:0] pat;
    pat = 10'b1010101010;
    do_reset();
    push_a(8'h55, 10, ok);
    vec_cnt++; if (level_a !== 3'd1 || busy_a !== 1'b1) begin
      miss_cnt++; $display("FAIL basic_queued: got level %0d busy %b, required level 1 busy 1", level_a, busy_a); end
    set_ticks(1);
    @(negedge clk);
    #1;
    t0 = cyc;
    wait_start(1, 50, ok);
    vec_cnt++; if (!ok) begin miss_cnt++; $display("FAIL basic_start: got no start bit, required one within 50 clk"); return; end
    s = starts0[0];
    vec_cnt++; if (s - t0 !== 2) begin miss_cnt++; $display("FAIL basic_start_latency: got %0d clk, required 2", s - t0); end
    for (int k = 0; k < 10; k++) begin
      wait_cyc(s + k * 10 + 5);
      vec_cnt++;
      if (tx_a !== pat[k]) begin miss_cnt++; $display("FAIL basic_bit%0d: got %b, required %b", k, tx_a, pat[k]); end
    end
    wait_idle(200, b, ok);
    vec_cnt++; if (!ok || b - s !== 100) begin
      miss_cnt++; $display("FAIL basic_busy_drop: got %0d clk after start (ok=%b), required 100", b - s, ok); end
    vec_cnt++; if (q0.size() !== 0) begin miss_cnt++; $display("FAIL basic_drain: got %0d pending, required 0", q0.size()); end
  endtask

  task automatic test_parity();
    bit ok;
    int b;
    do_reset();
    set_ticks(1);
    push_p(8'h07, 20, ok);
    push_p(8'h00, 20, ok);
    wait_idle(800, b, ok);
    vec_cnt++; if (!ok || q1.size() !== 0 || q2.size() !== 0) begin
      miss_cnt++; $display("FAIL parity_drain: got ok=%b pending %0d/%0d, required idle with 0/0", ok, q1.size(), q2.size()); end
    vec_cnt++; if (par_log1.size() !== 2 || par_log2.size() !== 2) begin
      miss_cnt++; $display("FAIL parity_frames: got %0d/%0d frames, required 2/2", par_log1.size(), par_log2.size());
      return;
    end
    vec_cnt++; if (par_log1[0] !== 1'b1) begin miss_cnt++; $display("FAIL parity_even_07: got %b, required 1", par_log1[0]); end
    vec_cnt++; if (par_log1[1] !== 1'b0) begin miss_cnt++; $display("FAIL parity_even_00: got %b, required 0", par_log1[1]); end
    vec_cnt++; if (par_log2[0] !== 1'b0) begin miss_cnt++; $display("FAIL parity_odd_07: got %b, required 0", par_log2[0]); end
    vec_cnt++; if (par_log2[1] !== 1'b1) begin miss_cnt++; $display("FAIL parity_odd_00: got %b, required 1", par_log2[1]); end
    set_ticks(0);
  endtask

  task automatic test_fifo_full();
    bit ok;
    int b;
    do_reset();
    set_ticks(0);
    for (int i = 0; i < 4; i++) push_a(8'hA1 + 8'(i), 10, ok);
    vec_cnt++; if (level_a !== 3'd4 || in_ready_a !== 1'b0) begin
      miss_cnt++; $display("FAIL full_after4: got level %0d in_ready %b, required 4 and 0", level_a, in_ready_a); end
    push_a(8'hEE, 20, ok);
    vec_cnt++; if (ok !== 1'b0 || level_a !== 3'd4) begin
      miss_cnt++; $display("FAIL full_fifth_push: got accepted %b level %0d, required 0 and 4", ok, level_a); end
    starts0.delete();
    set_ticks(1);
    wait_idle(800, b, ok);
    vec_cnt++; if (!ok || starts0.size() !== 4) begin
      miss_cnt++; $display("FAIL full_frames: got %0d frames (idle=%b), required 4", starts0.size(), ok); return; end
    for (int i = 1; i < 4; i++) begin
      vec_cnt++;
      if (starts0[i] - starts0[i-1] !== 100) begin
        miss_cnt++; $display("FAIL full_b2b_gap%0d: got %0d clk, required 100", i, starts0[i] - starts0[i-1]); end
    end
    vec_cnt++; if (q0.size() !== 0) begin miss_cnt++; $display("FAIL full_drain: got %0d pending, required 0", q0.size()); end
    set_ticks(0);
  endtask

  task automatic test_push_pop();
    bit ok;
    int s1, b;
    do_reset();
    set_ticks(0);
    push_a(8'h11, 10, ok);
    push_a(8'h22, 10, ok);
    push_a(8'h33, 10, ok);
    starts0.delete();
    set_ticks(1);
    wait_start(1, 50, ok);
    vec_cnt++; if (!ok) begin miss_cnt++; $display("FAIL pp_start: got no start bit, required one within 50 clk"); return; end
    s1 = starts0[0];
    push_a(8'h44, 10, ok);
    vec_cnt++; if (level_a !== 3'd3) begin miss_cnt++; $display("FAIL pp_level_pre: got %0d, required 3", level_a); end
    wait_cyc(s1 + 99);
    in_data_a = 8'h55;
    in_valid_a = 1'b1;
    vec_cnt++; if (in_ready_a !== 1'b1) begin miss_cnt++; $display("FAIL pp_ready: got %b, required 1", in_ready_a); end
    q0.push_back(8'h55);
    @(negedge clk);
    in_valid_a = 1'b0;
    vec_cnt++; if (level_a !== 3'd3) begin miss_cnt++; $display("FAIL pp_same_clk_level: got %0d, required 3", level_a); end
    vec_cnt++; if (tx_a !== 1'b0) begin miss_cnt++; $display("FAIL pp_b2b_start: got tx %b, required 0", tx_a); end
    push_a(8'h66, 10, ok);
    vec_cnt++; if (level_a !== 3'd4 || in_ready_a !== 1'b0) begin
      miss_cnt++; $display("FAIL pp_full: got level %0d in_ready %b, required 4 and 0", level_a, in_ready_a); end
    push_a(8'h77, 300, ok);
    vec_cnt++; if (ok !== 1'b1 || level_a !== 3'd4) begin
      miss_cnt++; $display("FAIL pp_refill: got accepted %b level %0d, required 1 and 4", ok, level_a); end
    wait_idle(1200, b, ok);
    vec_cnt++; if (!ok || starts0.size() !== 7 || q0.size() !== 0) begin
      miss_cnt++; $display("FAIL pp_drain: got %0d frames %0d pending (idle=%b), required 7 and 0", starts0.size(), q0.size(), ok);
      return;
    end
    for (int i = 1; i < 7; i++) begin
      vec_cnt++;
      if (starts0[i] - starts0[i-1] !== 100) begin
        miss_cnt++; $display("FAIL pp_gap%0d: got %0d clk, required 100", i, starts0[i] - starts0[i-1]); end
    end
    set_ticks(0);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int s, b;
    do_reset();
    starts0.delete();
    set_ticks(1);
    push_a(8'hA3, 10, ok);
    wait_start(1, 50, ok);
    vec_cnt++; if (!ok) begin miss_cnt++; $display("FAIL rst_mid_start: got no start bit, required one within 50 clk"); return; end
    s = starts0[0];
    wait_cyc(s + 37);
    vec_cnt++; if (tx_a !== 1'b0) begin miss_cnt++; $display("FAIL rst_mid_bit2: got %b, required 0", tx_a); end
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (tx_a !== 1'b1 || level_a !== 3'd0 || busy_a !== 1'b0 || in_ready_a !== 1'b0) begin
      miss_cnt++; $display("FAIL rst_mid_async: got tx %b level %0d busy %b in_ready %b, required 1 0 0 0",
                           tx_a, level_a, busy_a, in_ready_a); end
    q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    starts0.delete();
    repeat (30) @(negedge clk);
    vec_cnt++; if (starts0.size() !== 0 || tx_a !== 1'b1) begin
      miss_cnt++; $display("FAIL rst_mid_no_resume: got %0d starts tx %b, required 0 and 1", starts0.size(), tx_a); end
    push_a(8'h3C, 10, ok);
    wait_idle(300, b, ok);
    vec_cnt++; if (!ok || starts0.size() !== 1 || q0.size() !== 0) begin
      miss_cnt++; $display("FAIL rst_mid_clean_frame: got %0d frames %0d pending (idle=%b), required 1 and 0",
                           starts0.size(), q0.size(), ok); end
    set_ticks(0);
  endtask

  task automatic test_square_wave();
    bit ok;
    int t0, s, b;
    do_reset();
    bit_T = 20;
    starts0.delete();
    push_a(8'h96, 10, ok);
    set_ticks(2);
    @(negedge clk);
    #1;
    t0 = cyc;
    wait_start(1, 50, ok);
    vec_cnt++; if (!ok) begin miss_cnt++; $display("FAIL sq_start: got no start bit, required one within 50 clk"); return; end
    s = starts0[0];
    vec_cnt++; if (s - t0 !== 2) begin miss_cnt++; $display("FAIL sq_start_latency: got %0d clk, required 2", s - t0); end
    wait_idle(400, b, ok);
    vec_cnt++; if (!ok || b - s !== 200) begin
      miss_cnt++; $display("FAIL sq_frame_len: got %0d clk (idle=%b), required 200", b - s, ok); end
    vec_cnt++; if (q0.size() !== 0 || starts0.size() !== 1) begin
      miss_cnt++; $display("FAIL sq_drain: got %0d pending %0d frames, required 0 and 1", q0.size(), starts0.size()); end
    set_ticks(0);
    bit_T = 10;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_fifo_full();
    test_push_pop();
    test_reset_mid_frame();
    test_square_wave();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
